// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl -- pipeline hazard controller for a five-stage pipeline.
//
// Generates the stage-register load enables, the flush and bubble controls,
// the EX operand forwarding selects and the data-memory request, and counts
// the cycles in which the PC is held.
//
// Build option: define FORWARD_EN to enable MEM/WB forwarding. The stall
// condition then drops to load-use only. Without it, fwd_a/fwd_b are tied
// to 00 and any pending EX/MEM write to an ID source register stalls.
//
// Ports
//   clk, rst                 clock; synchronous active-low reset
//   rs_id, rt_id             ID-stage source registers
//   rs_ex, rt_ex             EX-stage source registers
//   regwrite_ex, memread_ex, regaddr_ex                 EX-stage destination info
//   regwrite_mem, memread_mem, memwrite_mem, regaddr_mem  MEM-stage info
//   regwrite_wb, regaddr_wb  WB-stage destination info
//   branch_taken_ex          taken branch/jump resolved in EX
//   dmem_req / dmem_ack      data-memory handshake
//   pc_en .. mem2wb_en       stage-register load enables
//   if2id_flush, id2ex_flush, mem2wb_bubble  load zeros into the register
//   fwd_a, fwd_b             00 regfile, 01 WB result, 10 MEM aluout
//   state                    00 RUN, 01 MEM_WAIT
//   perf_stalls              saturating count of cycles with pc_en=0
//
// state     | meaning
// ----------+--------------------------------------------------------
// RUN       | normal operation, no outstanding unacknowledged access
// MEM_WAIT  | MEM-stage access issued, pipeline frozen until dmem_ack
module pipe_hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  rs_id,
  input  logic [4:0]  rt_id,
  input  logic [4:0]  rs_ex,
  input  logic [4:0]  rt_ex,
  input  logic        regwrite_ex,
  input  logic        memread_ex,
  input  logic [4:0]  regaddr_ex,
  input  logic        regwrite_mem,
  input  logic        memread_mem,
  input  logic        memwrite_mem,
  input  logic [4:0]  regaddr_mem,
  input  logic        regwrite_wb,
  input  logic [4:0]  regaddr_wb,
  input  logic        branch_taken_ex,
  output logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_en,
  output logic        if2id_en,
  output logic        id2ex_en,
  output logic        ex2mem_en,
  output logic        mem2wb_en,
  output logic        if2id_flush,
  output logic        id2ex_flush,
  output logic        mem2wb_bubble,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [1:0]  state,
  output logic [15:0] perf_stalls
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] perf_stalls_q, perf_stalls_d;

  logic mem_access;
  logic mem_stall;
  logic data_hazard;

  // Register 0 is hard-wired, so a write to it can never be a dependency.
  function automatic logic reg_hit(input logic we, input logic [4:0] dst,
                                   input logic [4:0] src);
    return we && (dst != 5'd0) && (dst == src);
  endfunction

  assign mem_access = memread_mem | memwrite_mem;
  // The stall is keyed on the handshake itself rather than the state so the
  // first cycle of an access (still in RUN) freezes the pipe as well.
  assign mem_stall  = mem_access & ~dmem_ack;
  assign dmem_req   = rst & mem_access;

`ifdef FORWARD_EN
  logic unused_fwd_cfg;
  assign unused_fwd_cfg = regwrite_ex;

  // Only a load in EX cannot be covered by forwarding.
  assign data_hazard = reg_hit(memread_ex, regaddr_ex, rs_id) |
                       reg_hit(memread_ex, regaddr_ex, rt_id);

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (rst) begin
      if (reg_hit(regwrite_mem, regaddr_mem, rs_ex))     fwd_a = 2'b10;
      else if (reg_hit(regwrite_wb, regaddr_wb, rs_ex))  fwd_a = 2'b01;
      if (reg_hit(regwrite_mem, regaddr_mem, rt_ex))     fwd_b = 2'b10;
      else if (reg_hit(regwrite_wb, regaddr_wb, rt_ex))  fwd_b = 2'b01;
    end
  end
`else
  logic unused_fwd_cfg;
  assign unused_fwd_cfg = ^{rs_ex, rt_ex, memread_ex, regwrite_wb, regaddr_wb};

  // WB is omitted: the register file writes through to the ID read.
  assign data_hazard = reg_hit(regwrite_ex,  regaddr_ex,  rs_id) |
                       reg_hit(regwrite_ex,  regaddr_ex,  rt_id) |
                       reg_hit(regwrite_mem, regaddr_mem, rs_id) |
                       reg_hit(regwrite_mem, regaddr_mem, rt_id);

  assign fwd_a = 2'b00;
  assign fwd_b = 2'b00;
`endif

  always_comb begin
    state_d = state_q;
    if (!rst) begin
      state_d = ST_RUN;
    end else begin
      case (state_q)
        ST_RUN:      if (mem_stall) state_d = ST_MEM_WAIT;
        ST_MEM_WAIT: if (dmem_ack)  state_d = ST_RUN;
        default:                    state_d = ST_RUN;
      endcase
    end
  end

  always_comb begin
    pc_en         = 1'b1;
    if2id_en      = 1'b1;
    id2ex_en      = 1'b1;
    ex2mem_en     = 1'b1;
    mem2wb_en     = 1'b1;
    if2id_flush   = 1'b0;
    id2ex_flush   = 1'b0;
    mem2wb_bubble = 1'b0;
    if (!rst) begin
      pc_en         = 1'b0;
      if2id_en      = 1'b0;
      id2ex_en      = 1'b0;
      ex2mem_en     = 1'b0;
      mem2wb_en     = 1'b0;
      if2id_flush   = 1'b1;
      id2ex_flush   = 1'b1;
      mem2wb_bubble = 1'b1;
    end else if (mem_stall) begin
      pc_en         = 1'b0;
      if2id_en      = 1'b0;
      id2ex_en      = 1'b0;
      ex2mem_en     = 1'b0;
      mem2wb_en     = 1'b0;
      mem2wb_bubble = 1'b1;
    end else if (branch_taken_ex) begin
      // Wrong-path instructions are squashed, which also cancels any stall
      // they would have caused.
      if2id_flush = 1'b1;
      id2ex_flush = 1'b1;
    end else if (data_hazard) begin
      pc_en       = 1'b0;
      if2id_en    = 1'b0;
      id2ex_flush = 1'b1;
    end
  end

  always_comb begin
    perf_stalls_d = perf_stalls_q;
    if (!rst)
      perf_stalls_d = 16'd0;
    else if (!pc_en && (perf_stalls_q != 16'hFFFF))
      perf_stalls_d = perf_stalls_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    state_q       <= state_d;
    perf_stalls_q <= perf_stalls_d;
  end

  assign state       = state_q;
  assign perf_stalls = perf_stalls_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  rs_id, rt_id, rs_ex, rt_ex;
  logic        regwrite_ex, memread_ex;
  logic [4:0]  regaddr_ex;
  logic        regwrite_mem, memread_mem, memwrite_mem;
  logic [4:0]  regaddr_mem;
  logic        regwrite_wb;
  logic [4:0]  regaddr_wb;
  logic        branch_taken_ex;
  logic        dmem_req, dmem_ack;
  logic        pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en;
  logic        if2id_flush, id2ex_flush, mem2wb_bubble;
  logic [1:0]  fwd_a, fwd_b, state;
  logic [15:0] perf_stalls;

  int errors = 0;
  int checks = 0;

  logic [4:0] en;
  logic [2:0] fl;
  assign en = {pc_en, if2id_en, id2ex_en, ex2mem_en, mem2wb_en};
  assign fl = {if2id_flush, id2ex_flush, mem2wb_bubble};

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .rs_id(rs_id), .rt_id(rt_id), .rs_ex(rs_ex), .rt_ex(rt_ex),
    .regwrite_ex(regwrite_ex), .memread_ex(memread_ex), .regaddr_ex(regaddr_ex),
    .regwrite_mem(regwrite_mem), .memread_mem(memread_mem),
    .memwrite_mem(memwrite_mem), .regaddr_mem(regaddr_mem),
    .regwrite_wb(regwrite_wb), .regaddr_wb(regaddr_wb),
    .branch_taken_ex(branch_taken_ex),
    .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .if2id_en(if2id_en), .id2ex_en(id2ex_en),
    .ex2mem_en(ex2mem_en), .mem2wb_en(mem2wb_en),
    .if2id_flush(if2id_flush), .id2ex_flush(id2ex_flush),
    .mem2wb_bubble(mem2wb_bubble),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .state(state), .perf_stalls(perf_stalls)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    rs_id = 0; rt_id = 0; rs_ex = 0; rt_ex = 0;
    regwrite_ex = 0; memread_ex = 0; regaddr_ex = 0;
    regwrite_mem = 0; memread_mem = 0; memwrite_mem = 0; regaddr_mem = 0;
    regwrite_wb = 0; regaddr_wb = 0;
    branch_taken_ex = 0; dmem_ack = 0;
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b0;
    memread_mem = 1'b1;             // request must stay masked in reset
    tick(); tick();
    #1;
    chk("rst_state", 16'(state), 16'h0);
    chk("rst_perf", perf_stalls, 16'h0);
    chk("rst_en", 16'(en), 16'h00);
    chk("rst_flush", 16'(fl), 16'h7);
    chk("rst_req", 16'(dmem_req), 16'h0);
    chk("rst_fwd", 16'({fwd_a, fwd_b}), 16'h0);

    // normal advance
    tick();
    rst = 1'b1; idle();
    #1;
    chk("run_en", 16'(en), 16'h1F);
    chk("run_flush", 16'(fl), 16'h0);

    // memory stall: ack low 3 cycles then high
    tick();
    memread_mem = 1'b1; dmem_ack = 1'b0;
    #1;
    chk("ms1_state", 16'(state), 16'h0);
    chk("ms1_en", 16'(en), 16'h00);
    chk("ms1_flush", 16'(fl), 16'h1);
    chk("ms1_req", 16'(dmem_req), 16'h1);
    tick();
    branch_taken_ex = 1'b1; memread_ex = 1'b1; regaddr_ex = 5'd2; rs_id = 5'd2;
    #1;
    chk("ms2_state", 16'(state), 16'h1);
    chk("ms2_en", 16'(en), 16'h00);
    chk("ms2_flush_prio", 16'(fl), 16'h1);
    tick();
    branch_taken_ex = 1'b0; memread_ex = 1'b0; regaddr_ex = 0; rs_id = 0;
    #1;
    chk("ms3_state", 16'(state), 16'h1);
    chk("ms3_req", 16'(dmem_req), 16'h1);
    tick();
    dmem_ack = 1'b1;
    #1;
    chk("ms4_state", 16'(state), 16'h1);
    chk("ms4_en", 16'(en), 16'h1F);
    chk("ms4_flush", 16'(fl), 16'h0);
    chk("ms4_req", 16'(dmem_req), 16'h1);
    tick();
    idle();
    #1;
    chk("ms5_state", 16'(state), 16'h0);
    chk("ms5_req", 16'(dmem_req), 16'h0);
    chk("ms_perf", perf_stalls, 16'd3);

    // branch taken together with a load-use hazard
    tick();
    memread_ex = 1'b1; regwrite_ex = 1'b1; regaddr_ex = 5'd2; rs_id = 5'd2;
    branch_taken_ex = 1'b1;
    #1;
    chk("br_en", 16'(en), 16'h1F);
    chk("br_flush", 16'(fl), 16'h6);
    tick();
    idle();
    #1;
    chk("br_perf", perf_stalls, 16'd3);

    // lw $2 in EX, add using $2 in ID
    memread_ex = 1'b1; regwrite_ex = 1'b1; regaddr_ex = 5'd2; rs_id = 5'd2;
    #1;
    chk("lu1_en", 16'(en), 16'h07);
    chk("lu1_flush", 16'(fl), 16'h2);
    tick();
    idle();
    memread_mem = 1'b1; regwrite_mem = 1'b1; regaddr_mem = 5'd2; dmem_ack = 1'b1;
    rs_ex = 5'd2;
    #1;
    chk("lu2_en", 16'(en), 16'h1F);
`ifdef FORWARD_EN
    chk("lu2_fwd_a", 16'(fwd_a), 16'h2);
`else
    chk("lu2_fwd_a", 16'(fwd_a), 16'h0);
`endif
    chk("lu2_perf", perf_stalls, 16'd4);

    // add $3 in EX, sub using $3 in ID
    tick();
    idle();
    regwrite_ex = 1'b1; regaddr_ex = 5'd3; rt_id = 5'd3;
    #1;
`ifdef FORWARD_EN
    chk("alu1_en", 16'(en), 16'h1F);
`else
    chk("alu1_en", 16'(en), 16'h07);
`endif
    tick();
    idle();
    regwrite_mem = 1'b1; regaddr_mem = 5'd3; rt_id = 5'd3;
    #1;
`ifdef FORWARD_EN
    chk("alu2_en", 16'(en), 16'h1F);
`else
    chk("alu2_en", 16'(en), 16'h07);
`endif
    chk("alu2_fwd", 16'({fwd_a, fwd_b}), 16'h0);
    tick();
    idle();
    regwrite_wb = 1'b1; regaddr_wb = 5'd3; rt_id = 5'd3;
    #1;
    chk("alu3_wb_no_stall", 16'(en), 16'h1F);
`ifdef FORWARD_EN
    chk("alu_perf", perf_stalls, 16'd4);
`else
    chk("alu_perf", perf_stalls, 16'd6);
`endif

    // register 0 never hazards
    tick();
    idle();
    regwrite_ex = 1'b1; memread_ex = 1'b1; regaddr_ex = 5'd0;
    regwrite_mem = 1'b1; regaddr_mem = 5'd0;
    #1;
    chk("r0_en", 16'(en), 16'h1F);

    // forwarding priority and register 0
    idle();
    regwrite_mem = 1'b1; regaddr_mem = 5'd5; regwrite_wb = 1'b1; regaddr_wb = 5'd5;
    rs_ex = 5'd5; rt_ex = 5'd5;
    #1;
`ifdef FORWARD_EN
    chk("fw_mem_prio", 16'({fwd_a, fwd_b}), 16'hA);
`else
    chk("fw_mem_prio", 16'({fwd_a, fwd_b}), 16'h0);
`endif
    regwrite_mem = 1'b0;
    #1;
`ifdef FORWARD_EN
    chk("fw_wb", 16'({fwd_a, fwd_b}), 16'h5);
`else
    chk("fw_wb", 16'({fwd_a, fwd_b}), 16'h0);
`endif
    regwrite_mem = 1'b1; regaddr_mem = 5'd0; regaddr_wb = 5'd0; rs_ex = 5'd0; rt_ex = 5'd0;
    #1;
    chk("fw_r0", 16'({fwd_a, fwd_b}), 16'h0);

    // reset while waiting on memory
    tick();
    idle();
    memwrite_mem = 1'b1;
    tick();
    #1;
    chk("rw_state_wait", 16'(state), 16'h1);
    rst = 1'b0;
    #1;
    chk("rw_en", 16'(en), 16'h00);
    chk("rw_flush", 16'(fl), 16'h7);
    chk("rw_req", 16'(dmem_req), 16'h0);
    tick();
    #1;
    chk("rw_state", 16'(state), 16'h0);
    chk("rw_perf", perf_stalls, 16'h0);
    rst = 1'b1; memwrite_mem = 1'b0;
    #1;
    chk("rw_release_en", 16'(en), 16'h1F);

    // saturation of the stall counter
    tick();
    memread_mem = 1'b1; dmem_ack = 1'b0;
    repeat (65534) @(posedge clk);
    #1;
    chk("sat_fffe", perf_stalls, 16'hFFFE);
    tick();
    chk("sat_ffff", perf_stalls, 16'hFFFF);
    tick();
    chk("sat_hold", perf_stalls, 16'hFFFF);
    dmem_ack = 1'b1;
    tick();
    idle();
    #1;
    chk("sat_exit_state", 16'(state), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
